fibo_stream_gen: RTL and testbench

- Parametrised Fibonacci sequence generator that streams one term per accepted handshake.
- Generalises the fixed 8-bit, hold-gated generator to:
  - configurable term width;
  - configurable seeds;
  - an optional terminal term count;
  - wrap or saturate arithmetic;
  - a sticky overflow flag;
  - a valid/ready output.
- Sits as a test-pattern and stimulus source in the regression designs, feeding downstream consumers.

---
 rtl/fibo_stream_gen.sv | 147 ++++++++++++++
 tb/tb_fibo_stream_gen.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/fibo_stream_gen.sv
// fibo_stream_gen
// Fibonacci term generator that streams one term per valid/ready handshake.
// Two term registers (a, b) hold consecutive terms; a is always the term on
// the output. Each accepted term advances the pair to (b, a+b), with either
// modulo-2^W wrap or saturation at all-ones, and a sticky flag records any
// carry-out seen during the current run. An optional terminal count ends the
// run in DONE, from which start restarts from the seeds.
//
// Ports:
//   clk        clock, all state updates on rising edge
//   rst        synchronous active-low reset
//   start      IDLE->RUN, or DONE->RUN with seed reload
//   hold       pauses the stream: withdraws out_valid and freezes state
//   sat_mode   0 = wrap modulo 2^W, 1 = saturate at 2^W-1 (sampled per fire)
//   load       in IDLE, load a/b from load_a/load_b
//   load_a     value for a on load
//   load_b     value for b on load
//   out_ready  consumer ready
//   out_valid  term valid
//   out_data   current term (register a)
//   out_last   current term is the final term of the run
//   out_idx    index of the current term within the run
//   ovf        sticky carry-out flag for the current run
//   done       run finished (DONE state)

module fibo_stream_gen #(
  parameter int unsigned       W      = 8,
  parameter logic [W-1:0]      SEED_A = W'(0),
  parameter logic [W-1:0]      SEED_B = W'(1),
  parameter int unsigned       LIMIT  = 0,
  parameter int unsigned       CW     = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          hold,
  input  logic          sat_mode,
  input  logic          load,
  input  logic [W-1:0]  load_a,
  input  logic [W-1:0]  load_b,
  input  logic          out_ready,
  output logic          out_valid,
  output logic [W-1:0]  out_data,
  output logic          out_last,
  output logic [CW-1:0] out_idx,
  output logic          ovf,
  output logic          done
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // LIMIT of zero means free-running; LAST_IDX is then never consulted.
  localparam logic            HAS_LIMIT = (LIMIT != 0);
  localparam logic [CW-1:0]   LAST_IDX  = (LIMIT == 0) ? '0 : CW'(LIMIT - 1);

  state_t        state_q, state_d;
  logic [W-1:0]  a_q, a_d;
  logic [W-1:0]  b_q, b_d;
  logic [CW-1:0] idx_q, idx_d;
  logic          ovf_q, ovf_d;

  logic          fire;
  logic [W:0]    sum;
  logic [W-1:0]  next_b;

  assign out_data  = a_q;
  assign out_idx   = idx_q;
  assign ovf       = ovf_q;
  assign done      = (state_q == ST_DONE);
  assign out_valid = (state_q == ST_RUN) & ~hold;
  assign out_last  = out_valid & HAS_LIMIT & (idx_q == LAST_IDX);
  assign fire      = out_valid & out_ready;

  // Extra bit captures the carry that drives both saturation and ovf.
  assign sum    = {1'b0, a_q} + {1'b0, b_q};
  assign next_b = (sat_mode && sum[W]) ? {W{1'b1}} : sum[W-1:0];

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    idx_d   = idx_q;
    ovf_d   = ovf_q;

    case (state_q)
      ST_IDLE: begin
        if (load) begin
          a_d   = load_a;
          b_d   = load_b;
          idx_d = '0;
          ovf_d = 1'b0;
        end
        if (start) begin
          state_d = ST_RUN;
        end
      end

      ST_RUN: begin
        if (fire) begin
          a_d   = b_q;
          b_d   = next_b;
          ovf_d = ovf_q | sum[W];
          // A free-running idx simply wraps at 2^CW.
          idx_d = idx_q + CW'(1);
          if (out_last) begin
            state_d = ST_DONE;
          end
        end
      end

      ST_DONE: begin
        if (start) begin
          a_d     = SEED_A;
          b_d     = SEED_B;
          idx_d   = '0;
          ovf_d   = 1'b0;
          state_d = ST_RUN;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      a_q     <= SEED_A;
      b_q     <= SEED_B;
      idx_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      idx_q   <= idx_d;
      ovf_q   <= ovf_d;
    end
  end

endmodule

// File: tb/tb_fibo_stream_gen.sv
// tb_fibo_stream_gen
// Drives a free-running instance through a table of single-cycle vectors
// and a LIMIT=6 instance through a hand-written terminal-count sequence.

module tb_fibo_stream_gen;

  localparam int W  = 8;
  localparam int CW = 16;

  logic          clk;
  logic          rst;

  logic          start, hold, sat_mode, load, out_ready;
  logic [W-1:0]  load_a, load_b;
  logic          out_valid, out_last, ovf, done;
  logic [W-1:0]  out_data;
  logic [CW-1:0] out_idx;

  logic          l_start, l_hold, l_sat_mode, l_load, l_out_ready;
  logic [W-1:0]  l_load_a, l_load_b;
  logic          l_out_valid, l_out_last, l_ovf, l_done;
  logic [W-1:0]  l_out_data;
  logic [CW-1:0] l_out_idx;

  int n_cmp  = 0;
  int n_fail = 0;

  int fib [15] = '{0, 1, 1, 2, 3, 5, 8, 13, 21, 34, 55, 89, 144, 233, 121};

  typedef struct {
    logic          rst_n, start, load, hold, rdy, sat;
    logic [W-1:0]  la, lb;
    logic          e_valid;
    logic [W-1:0]  e_data;
    logic          e_last;
    logic [CW-1:0] e_idx;
    logic          e_ovf, e_done;
  } vec_t;

  vec_t vecs[$];

  fibo_stream_gen #(.W(W), .SEED_A(8'd0), .SEED_B(8'd1), .LIMIT(0), .CW(CW)) dut (
    .clk(clk), .rst(rst), .start(start), .hold(hold), .sat_mode(sat_mode),
    .load(load), .load_a(load_a), .load_b(load_b), .out_ready(out_ready),
    .out_valid(out_valid), .out_data(out_data), .out_last(out_last),
    .out_idx(out_idx), .ovf(ovf), .done(done)
  );

  fibo_stream_gen #(.W(W), .SEED_A(8'd0), .SEED_B(8'd1), .LIMIT(6), .CW(CW)) dut_lim (
    .clk(clk), .rst(rst), .start(l_start), .hold(l_hold), .sat_mode(l_sat_mode),
    .load(l_load), .load_a(l_load_a), .load_b(l_load_b), .out_ready(l_out_ready),
    .out_valid(l_out_valid), .out_data(l_out_data), .out_last(l_out_last),
    .out_idx(l_out_idx), .ovf(l_ovf), .done(l_done)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic addVec(input logic r, input logic s, input logic ld, input logic h,
                        input logic rd, input logic st, input logic [W-1:0] la,
                        input logic [W-1:0] lb, input logic ev, input logic [W-1:0] ed,
                        input logic el, input logic [CW-1:0] ei, input logic eo,
                        input logic edn);
    vec_t v;
    v.rst_n = r;  v.start = s;  v.load = ld; v.hold = h; v.rdy = rd; v.sat = st;
    v.la = la;    v.lb = lb;
    v.e_valid = ev; v.e_data = ed; v.e_last = el; v.e_idx = ei;
    v.e_ovf = eo;   v.e_done = edn;
    vecs.push_back(v);
  endtask

  task automatic applyStimulus(input vec_t v);
    rst       = v.rst_n;
    start     = v.start;
    load      = v.load;
    hold      = v.hold;
    out_ready = v.rdy;
    sat_mode  = v.sat;
    load_a    = v.la;
    load_b    = v.lb;
  endtask

  task automatic checkOutput(input bit lim, input string tag, input logic ev,
                             input logic [W-1:0] ed, input logic el,
                             input logic [CW-1:0] ei, input logic eo, input logic edn);
    if (lim) begin
      chk({tag, ".valid"}, 32'(l_out_valid), 32'(ev));
      chk({tag, ".data"},  32'(l_out_data),  32'(ed));
      chk({tag, ".last"},  32'(l_out_last),  32'(el));
      chk({tag, ".idx"},   32'(l_out_idx),   32'(ei));
      chk({tag, ".ovf"},   32'(l_ovf),       32'(eo));
      chk({tag, ".done"},  32'(l_done),      32'(edn));
    end else begin
      chk({tag, ".valid"}, 32'(out_valid), 32'(ev));
      chk({tag, ".data"},  32'(out_data),  32'(ed));
      chk({tag, ".last"},  32'(out_last),  32'(el));
      chk({tag, ".idx"},   32'(out_idx),   32'(ei));
      chk({tag, ".ovf"},   32'(ovf),       32'(eo));
      chk({tag, ".done"},  32'(done),      32'(edn));
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Each table entry: inputs applied, outputs compared, then one clock edge.
  task automatic buildTable();
    // Wrap-mode stream from reset.
    addVec(1, 1, 0, 0, 0, 0, 0, 0,   0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 15; i++)
      addVec(1, 0, 0, 0, 1, 0, 0, 0, 1, W'(fib[i]), 0, CW'(i), (i >= 13), 0);
    addVec(0, 0, 0, 1, 0, 0, 0, 0,   0, 98, 0, 15, 1, 0);

    // Saturating stream.
    addVec(1, 1, 0, 0, 0, 1, 0, 0,   0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 13; i++)
      addVec(1, 0, 0, 0, 1, 1, 0, 0, 1, W'(fib[i]), 0, CW'(i), 0, 0);
    addVec(1, 0, 0, 0, 1, 1, 0, 0,   1, 233, 0, 13, 1, 0);
    addVec(1, 0, 0, 0, 1, 1, 0, 0,   1, 255, 0, 14, 1, 0);
    addVec(1, 0, 0, 0, 1, 1, 0, 0,   1, 255, 0, 15, 1, 0);
    addVec(1, 0, 0, 0, 1, 1, 0, 0,   1, 255, 0, 16, 1, 0);
    addVec(0, 0, 0, 1, 0, 1, 0, 0,   0, 255, 0, 17, 1, 0);

    // Ready stall then hold at idx 5.
    addVec(1, 1, 0, 0, 0, 0, 0, 0,   0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 5; i++)
      addVec(1, 0, 0, 0, 1, 0, 0, 0, 1, W'(fib[i]), 0, CW'(i), 0, 0);
    for (int i = 0; i < 3; i++)
      addVec(1, 0, 0, 0, 0, 0, 0, 0, 1, 5, 0, 5, 0, 0);
    for (int i = 0; i < 2; i++)
      addVec(1, 0, 0, 1, 1, 0, 0, 0, 0, 5, 0, 5, 0, 0);
    addVec(1, 0, 0, 0, 1, 0, 0, 0,   1, 5, 0, 5, 0, 0);
    addVec(1, 0, 0, 0, 1, 0, 0, 0,   1, 8, 0, 6, 0, 0);
    addVec(1, 0, 0, 0, 1, 0, 0, 0,   1, 13, 0, 7, 0, 0);
    addVec(0, 0, 0, 1, 0, 0, 0, 0,   0, 21, 0, 8, 0, 0);

    // Load in IDLE, then start; load during RUN must be ignored.
    addVec(1, 0, 1, 0, 0, 0, 7, 11,  0, 0, 0, 0, 0, 0);
    addVec(1, 1, 0, 0, 0, 0, 0, 0,   0, 7, 0, 0, 0, 0);
    addVec(1, 0, 1, 0, 1, 0, 100, 200, 1, 7, 0, 0, 0, 0);
    addVec(1, 0, 1, 0, 1, 0, 100, 200, 1, 11, 0, 1, 0, 0);
    addVec(1, 0, 1, 0, 1, 0, 100, 200, 1, 18, 0, 2, 0, 0);
    addVec(1, 0, 1, 0, 1, 0, 100, 200, 1, 29, 0, 3, 0, 0);
    addVec(1, 0, 1, 0, 1, 0, 100, 200, 1, 47, 0, 4, 0, 0);
    addVec(0, 0, 0, 1, 0, 0, 0, 0,   0, 76, 0, 5, 0, 0);

    // Load and start together: first term is load_a.
    addVec(1, 1, 1, 0, 0, 0, 3, 4,   0, 0, 0, 0, 0, 0);
    addVec(1, 0, 0, 0, 1, 0, 0, 0,   1, 3, 0, 0, 0, 0);
    addVec(1, 0, 0, 0, 1, 0, 0, 0,   1, 4, 0, 1, 0, 0);
    addVec(1, 0, 0, 0, 1, 0, 0, 0,   1, 7, 0, 2, 0, 0);
    addVec(0, 0, 0, 1, 0, 0, 0, 0,   0, 11, 0, 3, 0, 0);

    // Synchronous reset mid-run at idx 9.
    addVec(1, 1, 0, 0, 0, 0, 0, 0,   0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 9; i++)
      addVec(1, 0, 0, 0, 1, 0, 0, 0, 1, W'(fib[i]), 0, CW'(i), 0, 0);
    addVec(0, 0, 0, 0, 1, 0, 0, 0,   1, 34, 0, 9, 0, 0);
    addVec(1, 0, 0, 0, 1, 0, 0, 0,   0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    rst = 1'b0; start = 0; hold = 0; sat_mode = 0; load = 0; out_ready = 0;
    load_a = '0; load_b = '0;
    l_start = 0; l_hold = 0; l_sat_mode = 0; l_load = 0; l_out_ready = 0;
    l_load_a = '0; l_load_b = '0;

    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    checkOutput(0, "reset", 0, 0, 0, 0, 0, 0);
    checkOutput(1, "lim_reset", 0, 0, 0, 0, 0, 0);

    buildTable();
    step();
    foreach (vecs[i]) begin
      applyStimulus(vecs[i]);
      #1;
      checkOutput(0, $sformatf("vec%0d", i), vecs[i].e_valid, vecs[i].e_data,
                  vecs[i].e_last, vecs[i].e_idx, vecs[i].e_ovf, vecs[i].e_done);
      step();
    end

    // A reset pulse entirely between clock edges must not disturb the run.
    rst = 1; start = 1; load = 0; hold = 0; out_ready = 0; sat_mode = 0;
    step();
    start = 0; out_ready = 1;
    #1;
    checkOutput(0, "glitch_t0", 1, 0, 0, 0, 0, 0);
    #2 rst = 1'b0;
    #3 rst = 1'b1;
    step();
    checkOutput(0, "glitch_t1", 1, 1, 0, 1, 0, 0);
    step();
    checkOutput(0, "glitch_t2", 1, 1, 0, 2, 0, 0);
    out_ready = 0;

    // Terminal count on the LIMIT=6 instance.
    l_start = 1;
    #1;
    checkOutput(1, "lim_idle", 0, 0, 0, 0, 0, 0);
    step();
    l_start = 0; l_out_ready = 1;
    for (int i = 0; i < 6; i++) begin
      #1;
      checkOutput(1, $sformatf("lim_t%0d", i), 1, W'(fib[i]), (i == 5), CW'(i), 0, 0);
      step();
    end
    #1;
    checkOutput(1, "lim_done", 0, 8, 0, 6, 0, 1);
    step();
    checkOutput(1, "lim_done_hold", 0, 8, 0, 6, 0, 1);
    l_start = 1; l_load = 1; l_load_a = 99; l_load_b = 98;
    step();
    l_start = 0; l_load = 0;
    #1;
    checkOutput(1, "lim_restart0", 1, 0, 0, 0, 0, 0);
    step();
    checkOutput(1, "lim_restart1", 1, 1, 0, 1, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
